// File: rtl/dircc_application_pkg.sv
// ============================================================================
// Module      : dircc_application_pkg
// Description : Counter-application types shared between the counter send
//               and receive handlers: the user-state layout and the tick
//               message layout, plus a saturating 16-bit increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dircc_application_pkg;

    // Counter application view of user_state[31:0].
    typedef struct packed {
        logic [15:0] rts;
        logic [15:0] count;
    } dev_state_t;

    // Tick message view of a 64-bit packet payload.
    typedef struct packed {
        logic [47:0] reserved;
        logic [15:0] tick;
    } tick_msg_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dircc_pkg.sv
// ============================================================================
// Module      : dircc_pkg
// Description : Base DiRCC types shared by every DiRCC handler: the raw packet
//               payload, the device-state record held in state memory and the
//               framework-level dircc_state flag bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dircc_pkg;

    // Raw inbound/outbound packet payload.
    typedef logic [63:0] packet_data_t;

    // Device-state record as stored in state memory.
    //   dircc_state       : framework flag bits (STOPPED, DONE, ...)
    //   dircc_state_extra : framework-private, opaque to applications
    //   user_state        : application-defined state
    typedef struct packed {
        logic [7:0]  dircc_state;
        logic [15:0] dircc_state_extra;
        logic [63:0] user_state;
    } device_state_t;

    localparam logic [7:0] DIRCC_STATE_STOPPED = 8'h01;
    localparam logic [7:0] DIRCC_STATE_DONE    = 8'h02;

endpackage

`default_nettype wire

// File: rtl/dircc_counter_receive_handler.sv
// ============================================================================
// Module      : dircc_counter_receive_handler
// Description : Receive side of the DiRCC counter application. Accepts one
//               tick packet at a time, reads the destination device state,
//               applies the counter update rule and writes the state back.
//               Bumping rts in the written state triggers the send handler.
// Ports       :
//   clk, reset_n               clock / asynchronous active-low reset
//   packet_in*                 inbound tick packet (valid/ready)
//   state_read_req, read_state*  device-state read port
//   state_address              address for both read and write
//   write_state*               device-state write port (one-cycle strobe)
//   busy                       read-modify-write in progress
//   packet_dropped             pulse: packet consumed without a write
//   protocol_error             pulse: tick ahead of local count
//   rx_count                   saturating count of accepted packets
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dircc_counter_receive_handler
    import dircc_pkg::*;
    import dircc_application_pkg::*;
#(
    parameter int          ADDRESS_MEM_WIDTH = 32,
    parameter logic [15:0] MAX_COUNT         = 16'd10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  packet_data_t                 packet_in,
    input  logic [ADDRESS_MEM_WIDTH-1:0] packet_in_address,
    input  logic                         packet_in_valid,
    output logic                         packet_in_ready,
    output logic                         state_read_req,
    output logic [ADDRESS_MEM_WIDTH-1:0] state_address,
    input  device_state_t                read_state,
    input  logic                         read_state_valid,
    output device_state_t                write_state,
    output logic                         write_state_valid,
    output logic                         busy,
    output logic                         packet_dropped,
    output logic                         protocol_error,
    output logic [31:0]                  rx_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [15:0]                    tick_q, tick_d;
    logic [ADDRESS_MEM_WIDTH-1:0]   addr_q, addr_d;
    device_state_t                  wstate_q, wstate_d;
    logic                           dropped_q, dropped_d;
    logic                           perr_q, perr_d;
    logic [31:0]                    rx_count_q, rx_count_d;

    tick_msg_t                      w_tick_msg;
    logic                           w_unused_reserved;

    assign w_tick_msg        = tick_msg_t'(packet_in);
    assign w_unused_reserved = ^w_tick_msg.reserved;

    // ------------------------------------------------------------------------
    // Counter update rule, evaluated on the returned state.
    // ------------------------------------------------------------------------
    dev_state_t    w_dev;
    dev_state_t    w_dev_new;
    device_state_t w_updated;
    logic          w_stopped;
    logic          w_advance;
    logic          w_stale;

    always_comb begin
        w_dev     = dev_state_t'(read_state.user_state[31:0]);
        w_stopped = (read_state.dircc_state & DIRCC_STATE_STOPPED) != 8'h00;
        w_advance = (tick_q == w_dev.count) && (w_dev.count < MAX_COUNT);
        w_stale   = (tick_q < w_dev.count) || (w_dev.count >= MAX_COUNT);

        w_dev_new.count = w_dev.count + 16'd1;
        w_dev_new.rts   = sat_inc16(w_dev.rts);

        // Everything outside user_state[31:0] passes through untouched.
        w_updated                  = read_state;
        w_updated.user_state[31:0] = w_dev_new;
        if (w_dev_new.count == MAX_COUNT) begin
            w_updated.dircc_state = read_state.dircc_state | DIRCC_STATE_DONE;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        addr_d     = addr_q;
        wstate_d   = wstate_q;
        dropped_d  = 1'b0;
        perr_d     = 1'b0;
        rx_count_d = rx_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (packet_in_valid) begin
                    tick_d     = w_tick_msg.tick;
                    addr_d     = packet_in_address;
                    rx_count_d = (rx_count_q == 32'hFFFF_FFFF) ? rx_count_q
                                                               : rx_count_q + 32'd1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (read_state_valid) begin
                    if (w_stopped) begin
                        dropped_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (w_advance) begin
                        wstate_d  = w_updated;
                        state_d   = S_WRITE;
                    end else if (w_stale) begin
                        dropped_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        dropped_d = 1'b1;
                        perr_d    = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            addr_q     <= '0;
            wstate_q   <= '0;
            dropped_q  <= 1'b0;
            perr_q     <= 1'b0;
            rx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            addr_q     <= addr_d;
            wstate_q   <= wstate_d;
            dropped_q  <= dropped_d;
            perr_q     <= perr_d;
            rx_count_q <= rx_count_d;
        end
    end

    assign packet_in_ready   = (state_q == S_IDLE);
    assign state_read_req    = (state_q == S_READ);
    assign write_state_valid = (state_q == S_WRITE);
    assign busy              = (state_q == S_READ) || (state_q == S_WRITE);
    assign state_address     = addr_q;
    assign write_state       = wstate_q;
    assign packet_dropped    = dropped_q;
    assign protocol_error    = perr_q;
    assign rx_count          = rx_count_q;

endmodule

`default_nettype wire
